smart_home_controller: RTL and testbench

- Synchronous home-automation controller (instantiated as SHS) that turns raw sensor levels into registered actuator enables.
- Climate control is a 3-state FSM driven by an 8-bit temperature reading.
- Lighting, security, gas, door and rain channels are independent one-cycle registered mappings.
- Sits between sensor front-end logic and actuator drivers.

---
 rtl/smart_home_controller.sv | 122 ++++++++++++
 tb/tb_smart_home_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/smart_home_controller.sv
// Purpose : maps raw home sensor levels to registered actuator enables; climate uses a 3-state FSM.
// Latency : 1 cycle from sampled inputs to all outputs; every output is a flop.
// Backpr. : none; inputs are sampled every rising edge and outputs follow unconditionally.
//
// Ports:
//   clk, reset (async, active-high)
//   temperature[7:0]                 unsigned degrees C, drives the OFF/FAN/AC FSM
//   light/motion/gas/door/rain_sensor single-bit sensor levels
//   fan, ac                          climate actuators (mutually exclusive)
//   room_light, security_alarm, exhaust_fan, door_lock, window_closer  channel actuators
module smart_home_controller #(
    parameter logic [7:0] FAN_THRESH = 8'd25,
    parameter logic [7:0] AC_THRESH  = 8'd28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] temperature,
    input  logic       light_sensor,
    input  logic       motion_sensor,
    input  logic       gas_sensor,
    input  logic       door_sensor,
    input  logic       rain_sensor,
    output logic       fan,
    output logic       ac,
    output logic       room_light,
    output logic       security_alarm,
    output logic       exhaust_fan,
    output logic       door_lock,
    output logic       window_closer
);

    typedef enum logic [1:0] {
        ST_OFF = 2'b00,
        ST_FAN = 2'b01,
        ST_AC  = 2'b10
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_fan_nxt;
    logic   w_ac_nxt;

    logic   r_fan;
    logic   r_ac;
    logic   r_room_light;
    logic   r_security_alarm;
    logic   r_exhaust_fan;
    logic   r_door_lock;
    logic   r_window_closer;

    // State register. fan/ac are registered alongside the state (decoded
    // from the next state) so they come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_OFF;
            r_fan   <= 1'b0;
            r_ac    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_fan   <= w_fan_nxt;
            r_ac    <= w_ac_nxt;
        end
    end

    // Next-state logic: no hysteresis, any state reaches any state in one
    // cycle. The illegal 2'b11 encoding is forced back to OFF.
    always_comb begin
        w_next_state = ST_OFF;
        case (r_state)
            ST_OFF, ST_FAN, ST_AC: begin
                if (temperature > AC_THRESH) begin
                    w_next_state = ST_AC;
                end else if (temperature > FAN_THRESH) begin
                    w_next_state = ST_FAN;
                end else begin
                    w_next_state = ST_OFF;
                end
            end
            default: w_next_state = ST_OFF;
        endcase
    end

    // Output decode of the state being entered; AC and FAN are exclusive states.
    always_comb begin
        w_fan_nxt = 1'b0;
        w_ac_nxt  = 1'b0;
        case (w_next_state)
            ST_FAN:  w_fan_nxt = 1'b1;
            ST_AC:   w_ac_nxt  = 1'b1;
            default: begin
                w_fan_nxt = 1'b0;
                w_ac_nxt  = 1'b0;
            end
        endcase
    end

    // Independent one-cycle channel mappings; no latching or stretching.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_room_light     <= 1'b0;
            r_security_alarm <= 1'b0;
            r_exhaust_fan    <= 1'b0;
            r_door_lock      <= 1'b0;
            r_window_closer  <= 1'b0;
        end else begin
            r_room_light     <= ~light_sensor;
            r_security_alarm <= motion_sensor;
            r_exhaust_fan    <= gas_sensor;
            r_door_lock      <= door_sensor;
            r_window_closer  <= rain_sensor;
        end
    end

    assign fan            = r_fan;
    assign ac             = r_ac;
    assign room_light     = r_room_light;
    assign security_alarm = r_security_alarm;
    assign exhaust_fan    = r_exhaust_fan;
    assign door_lock      = r_door_lock;
    assign window_closer  = r_window_closer;

endmodule

// File: tb/tb_smart_home_controller.sv
// Purpose : directed self-checking bench for smart_home_controller.
// Latency : outputs are checked 1 ns after the rising edge that samples the inputs.
// Backpr. : not applicable; stimulus is applied every cycle.
module tb_smart_home_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] temperature = 8'd0;
    logic       light_sensor = 1'b1;
    logic       motion_sensor = 1'b0;
    logic       gas_sensor = 1'b0;
    logic       door_sensor = 1'b0;
    logic       rain_sensor = 1'b0;
    logic       fan;
    logic       ac;
    logic       room_light;
    logic       security_alarm;
    logic       exhaust_fan;
    logic       door_lock;
    logic       window_closer;

    // Output vector order: fan, ac, room_light, security_alarm, exhaust_fan, door_lock, window_closer
    logic [6:0] outs;
    assign outs = {fan, ac, room_light, security_alarm, exhaust_fan, door_lock, window_closer};

    int checks = 0;
    int errors = 0;

    smart_home_controller dut (
        .clk            (clk),
        .reset          (reset),
        .temperature    (temperature),
        .light_sensor   (light_sensor),
        .motion_sensor  (motion_sensor),
        .gas_sensor     (gas_sensor),
        .door_sensor    (door_sensor),
        .rain_sensor    (rain_sensor),
        .fan            (fan),
        .ac             (ac),
        .room_light     (room_light),
        .security_alarm (security_alarm),
        .exhaust_fan    (exhaust_fan),
        .door_lock      (door_lock),
        .window_closer  (window_closer)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if (outs !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_held: outs=%b expected=%b", outs, 7'b0000000);
        end
        reset = 1'b0;
        step();
        checks++;
        if (outs !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_release: outs=%b expected=%b", outs, 7'b0000000);
        end
    endtask

    task automatic test_climate();
        logic [7:0] temps [0:7];
        logic [6:0] exp_o [0:7];
        temps[0] = 8'd26;  exp_o[0] = 7'b1000000;
        temps[1] = 8'd29;  exp_o[1] = 7'b0100000;
        temps[2] = 8'd24;  exp_o[2] = 7'b0000000;
        temps[3] = 8'd25;  exp_o[3] = 7'b0000000;
        temps[4] = 8'd28;  exp_o[4] = 7'b1000000;
        temps[5] = 8'd255; exp_o[5] = 7'b0100000;
        temps[6] = 8'd27;  exp_o[6] = 7'b1000000;
        temps[7] = 8'd0;   exp_o[7] = 7'b0000000;
        for (int i = 0; i < 8; i++) begin
            temperature = temps[i];
            step();
            checks++;
            if (outs !== exp_o[i]) begin
                errors++;
                $display("FAIL climate_t%0d: outs=%b expected=%b", temps[i], outs, exp_o[i]);
            end
        end
    endtask

    task automatic test_light();
        logic       lvals [0:2];
        logic [6:0] exp_o [0:2];
        lvals[0] = 1'b1; exp_o[0] = 7'b0000000;
        lvals[1] = 1'b0; exp_o[1] = 7'b0010000;
        lvals[2] = 1'b1; exp_o[2] = 7'b0000000;
        for (int i = 0; i < 3; i++) begin
            light_sensor = lvals[i];
            step();
            checks++;
            if (outs !== exp_o[i]) begin
                errors++;
                $display("FAIL light_%0d: outs=%b expected=%b", i, outs, exp_o[i]);
            end
        end
    endtask

    task automatic test_pulses();
        logic [3:0] sens;
        logic [6:0] exp_o;
        for (int i = 0; i < 4; i++) begin
            sens  = 4'b1000 >> i;
            exp_o = 7'b0001000 >> i;
            {motion_sensor, gas_sensor, door_sensor, rain_sensor} = sens;
            step();
            checks++;
            if (outs !== exp_o) begin
                errors++;
                $display("FAIL pulse_on_%0d: outs=%b expected=%b", i, outs, exp_o);
            end
            {motion_sensor, gas_sensor, door_sensor, rain_sensor} = 4'b0000;
            step();
            checks++;
            if (outs !== 7'b0000000) begin
                errors++;
                $display("FAIL pulse_off_%0d: outs=%b expected=%b", i, outs, 7'b0000000);
            end
        end
    endtask

    task automatic test_all_active();
        temperature = 8'd30;
        light_sensor = 1'b0;
        {motion_sensor, gas_sensor, door_sensor, rain_sensor} = 4'b1111;
        step();
        checks++;
        if (outs !== 7'b0111111) begin
            errors++;
            $display("FAIL all_active: outs=%b expected=%b", outs, 7'b0111111);
        end
    endtask

    task automatic test_async_reset();
        // Enter mid-cycle with every output active from test_all_active.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== 7'b0000000) begin
            errors++;
            $display("FAIL async_reset_assert: outs=%b expected=%b", outs, 7'b0000000);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== 7'b0000000) begin
            errors++;
            $display("FAIL async_reset_hold: outs=%b expected=%b", outs, 7'b0000000);
        end
        step();
        checks++;
        if (outs !== 7'b0111111) begin
            errors++;
            $display("FAIL async_reset_recover: outs=%b expected=%b", outs, 7'b0111111);
        end
    endtask

    task automatic test_back_to_back();
        // FSM jumps AC->OFF->AC->FAN on consecutive cycles with quiet channels.
        logic [7:0] temps [0:3];
        logic [6:0] exp_o [0:3];
        light_sensor = 1'b1;
        {motion_sensor, gas_sensor, door_sensor, rain_sensor} = 4'b0000;
        temps[0] = 8'd10;  exp_o[0] = 7'b0000000;
        temps[1] = 8'd100; exp_o[1] = 7'b0100000;
        temps[2] = 8'd26;  exp_o[2] = 7'b1000000;
        temps[3] = 8'd200; exp_o[3] = 7'b0100000;
        for (int i = 0; i < 4; i++) begin
            temperature = temps[i];
            step();
            checks++;
            if (outs !== exp_o[i]) begin
                errors++;
                $display("FAIL b2b_%0d: outs=%b expected=%b", i, outs, exp_o[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_climate();
        test_light();
        test_pulses();
        test_all_active();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
